// File: rtl/ksa_engine.sv
// RC4 key-scheduling engine: optionally fills an external S-box RAM with the
// identity permutation, then runs the key-driven swap pass over it.
module ksa_engine #(
  parameter int ADDR_W    = 8,
  parameter int KEY_BYTES = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   init_en,
  input  logic [8*KEY_BYTES-1:0] secret_key,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [ADDR_W-1:0]      mem_wdata,
  output logic                   mem_wren,
  input  logic [ADDR_W-1:0]      mem_rdata,
  output logic                   busy,
  output logic                   done,
  output logic [3:0]             dbg_status
);

  // Handshake: start is a level request accepted only while busy=0; once
  // accepted, busy stays high until (and including) the single done cycle,
  // and secret_key must be held stable for the whole busy window.

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_RD_SI,
    S_CALC_J,
    S_RD_SJ,
    S_WR_SI,
    S_WR_SJ,
    S_DONE
  } state_t;

  localparam int KW = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(KEY_BYTES - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] i_q, i_d;
  logic [ADDR_W-1:0] j_q, j_d;
  logic [ADDR_W-1:0] si_q, si_d;
  logic [KW-1:0]     k_q, k_d;
  logic              init_en_q, init_en_d;
  logic [7:0]        key_byte;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      i_q       <= '0;
      j_q       <= '0;
      si_q      <= '0;
      k_q       <= '0;
      init_en_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      i_q       <= i_d;
      j_q       <= j_d;
      si_q      <= si_d;
      k_q       <= k_d;
      init_en_q <= init_en_d;
    end
  end

  // Key byte 0 sits in the most significant byte of secret_key.
  always_comb begin
    key_byte = '0;
    for (int b = 0; b < KEY_BYTES; b++) begin
      if (k_q == KW'(b)) key_byte = secret_key[8*(KEY_BYTES-1-b) +: 8];
    end
  end

  always_comb begin
    state_d   = state_q;
    i_d       = i_q;
    j_d       = j_q;
    si_d      = si_q;
    k_d       = k_q;
    init_en_d = init_en_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          init_en_d = init_en;
          i_d       = '0;
          j_d       = '0;
          k_d       = '0;
          state_d   = init_en ? S_INIT : S_RD_SI;
        end
      end
      S_INIT: begin
        if (i_q == '1) begin
          i_d     = '0;
          state_d = S_RD_SI;
        end else begin
          i_d = i_q + ADDR_W'(1);
        end
      end
      S_RD_SI:  state_d = S_CALC_J;
      S_CALC_J: begin
        si_d    = mem_rdata;
        j_d     = j_q + mem_rdata + key_byte[ADDR_W-1:0];
        state_d = S_RD_SJ;
      end
      S_RD_SJ:  state_d = S_WR_SI;
      S_WR_SI:  state_d = S_WR_SJ;
      S_WR_SJ: begin
        if (i_q == '1) begin
          state_d = S_DONE;
        end else begin
          i_d     = i_q + ADDR_W'(1);
          k_d     = (k_q == K_LAST) ? '0 : k_q + KW'(1);
          state_d = S_RD_SI;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // When i==j the two write states store the same byte at the same address,
  // so the self-swap case needs no special handling.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_wren  = 1'b0;
    busy      = (state_q != S_IDLE);
    done      = (state_q == S_DONE);
    case (state_q)
      S_INIT: begin
        mem_addr  = i_q;
        mem_wdata = i_q;
        mem_wren  = 1'b1;
      end
      S_RD_SI: mem_addr = i_q;
      S_RD_SJ: mem_addr = j_q;
      S_WR_SI: begin
        // S[j] arrives straight from the RAM's registered read port.
        mem_addr  = i_q;
        mem_wdata = mem_rdata;
        mem_wren  = 1'b1;
      end
      S_WR_SJ: begin
        mem_addr  = j_q;
        mem_wdata = si_q;
        mem_wren  = 1'b1;
      end
      default: ;
    endcase
  end

  assign dbg_status = {init_en_q, state_q};

endmodule

// File: tb/tb_ksa_engine.sv
// Bench for ksa_engine: two instances (N=256/3-byte key and N=16/5-byte key)
// each on a modelled S-box RAM, scored against a plain RC4 KSA model.
module tb_ksa_engine;

  logic        clk = 1'b0;
  logic        reset;

  logic        start_b, init_b;
  logic [23:0] key_b;
  logic [7:0]  addr_b, wdata_b, rdata_b;
  logic        wren_b, busy_b, done_b;
  logic [3:0]  dbg_b;

  logic        start_s, init_s;
  logic [39:0] key_s;
  logic [3:0]  addr_s, wdata_s, rdata_s;
  logic        wren_s, busy_s, done_s;
  logic [3:0]  dbg_s;

  logic        pre_we;
  logic [3:0]  pre_addr, pre_data;

  logic [7:0]  ram [2][256];

  typedef struct packed {
    int inst;
    int start;
    int lat;
    int wr;
  } run_t;

  run_t       run_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];

  int checks = 0;
  int failures = 0;
  int ecount = 0;
  int done_seen = 0;
  int exp_done = 0;
  int wr_cnt[2] = '{0, 0};
  int busy_cnt[2] = '{0, 0};

  ksa_engine #(.ADDR_W(8), .KEY_BYTES(3)) u_big (
    .clk(clk), .reset(reset), .start(start_b), .init_en(init_b),
    .secret_key(key_b), .mem_addr(addr_b), .mem_wdata(wdata_b),
    .mem_wren(wren_b), .mem_rdata(rdata_b), .busy(busy_b), .done(done_b),
    .dbg_status(dbg_b)
  );

  ksa_engine #(.ADDR_W(4), .KEY_BYTES(5)) u_small (
    .clk(clk), .reset(reset), .start(start_s), .init_en(init_s),
    .secret_key(key_s), .mem_addr(addr_s), .mem_wdata(wdata_s),
    .mem_wren(wren_s), .mem_rdata(rdata_s), .busy(busy_s), .done(done_s),
    .dbg_status(dbg_s)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    forever begin
      @(posedge clk);
      ecount++;
    end
  end

  // Synchronous-read RAMs with a bench preload port on the small one.
  always @(posedge clk) begin
    if (wren_b) ram[0][addr_b] <= wdata_b;
    rdata_b <= ram[0][addr_b];
    if (pre_we) ram[1][pre_addr] <= {4'b0, pre_data};
    else if (wren_s) ram[1][addr_s] <= {4'b0, wdata_s};
    rdata_s <= ram[1][addr_s][3:0];
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Plain RC4 KSA over an array; key byte 0 is the most significant byte.
  task automatic model_push(input int inst, input bit init, input logic [39:0] key);
    int n, kb, j, t, kv;
    int s[256];
    n  = (inst == 0) ? 256 : 16;
    kb = (inst == 0) ? 3 : 5;
    for (int i = 0; i < n; i++) s[i] = init ? i : int'(ram[inst][i]);
    j = 0;
    for (int i = 0; i < n; i++) begin
      kv = int'(key[8*(kb-1-(i % kb)) +: 8]);
      j = (j + s[i] + kv) % n;
      t = s[i];
      s[i] = s[j];
      s[j] = t;
    end
    for (int i = 0; i < n; i++) exp_q.push_back(8'(s[i]));
  endtask

  task automatic push_run(input int inst, input bit init, input int k);
    run_t r;
    int n;
    n = (inst == 0) ? 256 : 16;
    r.inst  = inst;
    r.start = k;
    r.lat   = (init ? n : 0) + 5 * n + 1;
    r.wr    = (init ? n : 0) + 2 * n;
    run_q.push_back(r);
  endtask

  task automatic check_run(input int inst);
    run_t r;
    int n, bad, first;
    logic [7:0] e;
    chk("done_expected", (run_q.size() != 0) ? 1 : 0, 1);
    if (run_q.size() != 0) begin
      r = run_q.pop_front();
      chk("run_instance", inst, r.inst);
      chk("done_latency", ecount + 1 - r.start, r.lat);
      chk("busy_cycles", busy_cnt[inst], r.lat);
      chk("write_cycles", wr_cnt[inst], r.wr);
      n = (r.inst == 0) ? 256 : 16;
      bad = 0;
      first = -1;
      for (int i = 0; i < n; i++) begin
        e = exp_q.pop_front();
        if (ram[inst][i] !== e) begin
          bad++;
          if (first < 0) first = i;
        end
      end
      chk("sbox_mismatch_count", bad, 0);
      if (bad != 0) $display("  first differing S index %0d", first);
    end
    busy_cnt[inst] = 0;
    wr_cnt[inst] = 0;
    done_seen++;
  endtask

  // ---------------- monitor ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (reset) begin
        wr_cnt[0] = 0; wr_cnt[1] = 0;
        busy_cnt[0] = 0; busy_cnt[1] = 0;
      end else begin
        if (wren_b) wr_cnt[0]++;
        if (busy_b) busy_cnt[0]++;
        if (wren_s) begin
          wr_cnt[1]++;
          log_q.push_back({addr_s, wdata_s});
        end
        if (busy_s) busy_cnt[1]++;
        if (done_b) check_run(0);
        if (done_s) check_run(1);
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic launch(input int inst, input bit init, input logic [39:0] key, output int k);
    @(negedge clk);
    if (inst == 0) begin
      key_b = key[23:0]; init_b = init; start_b = 1'b1;
    end else begin
      key_s = key; init_s = init; start_s = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    k = ecount;
    start_b = 1'b0;
    start_s = 1'b0;
  endtask

  task automatic wait_done(input int target, input int budget);
    int c;
    c = 0;
    while (done_seen < target && c < budget) begin
      @(negedge clk);
      c++;
    end
    chk("done_within_budget", (done_seen >= target) ? 1 : 0, 1);
    if (done_seen < target) begin
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      run_q.delete();
      exp_q.delete();
      done_seen = target;
    end
  endtask

  task automatic run_simple(input int inst, input bit init, input logic [39:0] key);
    int k;
    model_push(inst, init, key);
    launch(inst, init, key, k);
    push_run(inst, init, k);
    exp_done++;
    wait_done(exp_done, 2000);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int k;
    logic [39:0] kr;
    logic [7:0] trace_exp[6];
    trace_exp = '{8'h00, 8'h00, 8'h11, 8'h11, 8'h23, 8'h32};

    reset = 1'b1;
    start_b = 1'b0; init_b = 1'b0; key_b = '0;
    start_s = 1'b0; init_s = 1'b0; key_s = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy_b", busy_b, 0);
    chk("rst_done_b", done_b, 0);
    chk("rst_wren_b", wren_b, 0);
    chk("rst_addr_b", addr_b, 0);
    chk("rst_wdata_b", wdata_b, 0);
    chk("rst_dbg_b", dbg_b, 0);
    chk("rst_busy_s", busy_s, 0);
    chk("rst_done_s", done_s, 0);
    chk("rst_wren_s", wren_s, 0);
    chk("rst_addr_s", addr_s, 0);
    chk("rst_wdata_s", wdata_s, 0);
    chk("rst_dbg_s", dbg_s, 0);
    reset = 1'b0;

    // Reference key "Key" on the 256-entry engine.
    run_simple(0, 1'b1, 40'h4B6579);

    // Zero key on N=16: first iterations are self-swaps, then S[2]<->S[3].
    log_q.delete();
    run_simple(1, 1'b1, 40'h0);
    chk("zero_key_log_len", log_q.size(), 48);
    for (int i = 0; i < 6; i++) chk("zero_key_trace", log_q[16 + i], trace_exp[i]);

    // Random 5-byte keys exercise the full key-index wrap.
    repeat (3) begin
      kr = {8'($urandom), $urandom};
      run_simple(1, 1'b1, kr);
    end

    // Shuffle only, over random preloaded contents.
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pre_we = 1'b1;
      pre_addr = 4'(i);
      pre_data = 4'($urandom_range(0, 15));
    end
    @(negedge clk);
    pre_we = 1'b0;
    kr = {8'($urandom), $urandom};
    run_simple(1, 1'b0, kr);

    // start toggled randomly throughout a run, released before IDLE.
    kr = {8'($urandom), $urandom};
    model_push(1, 1'b1, kr);
    launch(1, 1'b1, kr, k);
    push_run(1, 1'b1, k);
    exp_done++;
    while (ecount < k + 97) begin
      start_s = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    start_s = 1'b0;
    wait_done(exp_done, 400);
    repeat (3) @(negedge clk);
    chk("pulsed_no_rerun", busy_s, 0);

    // start held high: second run must begin after exactly one IDLE cycle.
    kr = {8'($urandom), $urandom};
    model_push(1, 1'b1, kr);
    model_push(1, 1'b1, kr);
    @(negedge clk);
    key_s = kr; init_s = 1'b1; start_s = 1'b1;
    @(posedge clk);
    @(negedge clk);
    k = ecount;
    push_run(1, 1'b1, k);
    push_run(1, 1'b1, k + 98);
    exp_done += 2;
    while (ecount < k + 98) @(negedge clk);
    start_s = 1'b0;
    wait_done(exp_done, 400);

    // A random key on the large engine.
    kr = {16'h0, 24'($urandom)};
    run_simple(0, 1'b1, kr);

    // Reset in WR_SI of iteration 100, then a clean rerun.
    launch(0, 1'b1, 40'h4B6579, k);
    while (ecount < k + 759) @(negedge clk);
    chk("iter100_wr_si_wren", wren_b, 1);
    chk("iter100_wr_si_addr", addr_b, 100);
    reset = 1'b1;
    #1;
    chk("midrst_busy", busy_b, 0);
    chk("midrst_wren", wren_b, 0);
    chk("midrst_addr", addr_b, 0);
    chk("midrst_done", done_b, 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    run_simple(0, 1'b1, 40'h4B6579);

    repeat (4) @(negedge clk);
    chk("runs_drained", run_q.size(), 0);
    chk("sbox_queue_drained", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ksa_engine.md
KSA_ENGINE -- requirements
Module: ksa_engine

Interface
REQ-001 Parameter: ADDR_W, 8, S-box address/data width (range 4..8); N = 2^ADDR_W entries.
REQ-002 Parameter: KEY_BYTES, 3, secret key length in bytes (range 1..16).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: reset  input  1  asynchronous, active-high; forces IDLE immediately.
REQ-005 Port: start  input  1  level request; sampled only in IDLE.
REQ-006 Port: init_en  input  1  sampled with start; 1 = run init phase S[i]=i before shuffle.
REQ-007 Port: secret_key  input  8*KEY_BYTES  key; byte 0 = MSB byte; held stable while busy.
REQ-008 Port: mem_addr  output  ADDR_W  S-box RAM address.
REQ-009 Port: mem_wdata  output  ADDR_W  S-box RAM write data.
REQ-010 Port: mem_wren  output  1  RAM write enable.
REQ-011 Port: mem_rdata  input  ADDR_W  RAM read data; valid the cycle after mem_addr presented with mem_wren=0.
REQ-012 Port: busy  output  1  high in every state except IDLE.
REQ-013 Port: done  output  1  one-cycle completion pulse.

Function
REQ-014 States: IDLE, INIT, RD_SI, CALC_J, RD_SJ, WR_SI, WR_SJ, DONE.
REQ-015 IDLE: start=1 -> latch init_en, clear i, j, k to 0; go INIT if init_en else RD_SI; start=0 -> stay.
REQ-016 INIT: mem_addr=i, mem_wdata=i, mem_wren=1; i==N-1 -> clear i, go RD_SI; else i++.
REQ-017 RD_SI: mem_addr=i, mem_wren=0; go CALC_J.
REQ-018 CALC_J: capture si=mem_rdata; j <= (j + mem_rdata + key[k][ADDR_W-1:0]) mod N; go RD_SJ.
REQ-019 RD_SJ: mem_addr=j (new value), mem_wren=0; go WR_SI.
REQ-020 WR_SI: mem_addr=i, mem_wdata=mem_rdata (S[j]), mem_wren=1; go WR_SJ.
REQ-021 WR_SJ: mem_addr=j, mem_wdata=si, mem_wren=1; i==N-1 -> DONE; else i++, k = (k==KEY_BYTES-1) ? 0 : k+1, go RD_SI.
REQ-022 DONE: done=1 for exactly one cycle; go IDLE unconditionally.
REQ-023 Key index k by wrapping counter, no divider/modulo; all index/j arithmetic truncates to ADDR_W bits.
REQ-024 i==j: WR_SI then WR_SJ write the same value to the same address; S unchanged.
REQ-025 Latency: start sampled at edge t -> done high in cycle t+1+(init_en?N:0)+5N; busy high for that many cycles plus the DONE cycle.
REQ-026 start while busy ignored; start held high through DONE -> new run begins after one IDLE cycle.
REQ-027 Moore outputs: function of state and internal registers only; no combinational input-to-output path.
REQ-028 Outside write states mem_wren=0; mem_addr/mem_wdata=0 in IDLE and DONE.

Reset
REQ-029 reset=1 -> state IDLE; i, j, k, si, latched init_en = 0; all outputs 0, including mid-operation.
REQ-030 RAM contents after mid-run reset unspecified; a new start with init_en=1 fully reinitialises.

Verification
REQ-031 ADDR_W=8, KEY_BYTES=3, key=0x4B6579, init_en=1: done in cycle 1537 after start edge; final S matches software RC4 KSA model; 768 write cycles total.
REQ-032 ADDR_W=4, KEY_BYTES=1, key=0x00, init_en=1: iterations i=0,1 give j=0,1 (self-swap, S unchanged); i=2 gives j=3, S[2]=3, S[3]=2.
REQ-033 ADDR_W=4, KEY_BYTES=5: k sequence 0,1,2,3,4,0,... over 16 iterations; final S matches model.
REQ-034 init_en=0 on preloaded RAM: no INIT writes; done at start edge +81 cycles (N=16).
REQ-035 Assert reset during WR_SI of iteration 100 (N=256): busy, mem_wren drop same cycle; restart with init_en=1 yields golden result.
REQ-036 start pulsed every cycle during run: exactly one done per run; held high: back-to-back runs separated by one IDLE cycle.
